// File: rtl/aes_statemt_ram.sv
// Home of the AES `statemt` state array: two engine ap_memory ports serviced in IDLE,
// plus a host stream path that loads/unloads XFER_LEN words at addresses 0..XFER_LEN-1.
module aes_statemt_ram #(
    parameter int DEPTH    = 32,
    parameter int XFER_LEN = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst,

    input  logic [4:0]  statemt_address0,
    input  logic        statemt_ce0,
    input  logic        statemt_we0,
    input  logic [31:0] statemt_d0,
    output logic [31:0] statemt_q0,

    input  logic [4:0]  statemt_address1,
    input  logic        statemt_ce1,
    input  logic        statemt_we1,
    input  logic [31:0] statemt_d1,
    output logic [31:0] statemt_q1,

    input  logic        load_start,
    input  logic        unload_start,

    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,

    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,

    output logic        busy,
    output logic        load_done,
    output logic        unload_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_UNLOAD_RD,
        S_UNLOAD_HOLD
    } state_t;

    state_t      r_state;
    logic [AW-1:0] r_cnt;
    logic        r_load_done;
    logic [31:0] r_q0;
    logic [31:0] r_q1;
    logic [31:0] r_out_data;

    logic [31:0] r_mem [0:DEPTH-1];

    logic w_idle;
    logic w_last;
    logic w_we0;
    logic w_we1;
    logic w_re0;
    logic w_re1;
    logic w_load_wr;

    assign w_idle    = (r_state == S_IDLE);
    assign w_last    = (r_cnt == AW'(XFER_LEN - 1));
    assign w_we0     = w_idle & statemt_ce0 & statemt_we0;
    assign w_we1     = w_idle & statemt_ce1 & statemt_we1;
    assign w_re0     = w_idle & statemt_ce0 & ~statemt_we0;
    assign w_re1     = w_idle & statemt_ce1 & ~statemt_we1;
    assign w_load_wr = (r_state == S_LOAD) & in_valid;

    // Port 0 is written last so it wins a same-address collision with port 1.
    always_ff @(posedge ap_clk) begin
        if (w_load_wr) begin
            r_mem[r_cnt] <= in_data;
        end
        if (w_we1) begin
            r_mem[statemt_address1[AW-1:0]] <= statemt_d1;
        end
        if (w_we0) begin
            r_mem[statemt_address0[AW-1:0]] <= statemt_d0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            if (w_re0) begin
                r_q0 <= r_mem[statemt_address0[AW-1:0]];
            end
            if (w_re1) begin
                r_q1 <= r_mem[statemt_address1[AW-1:0]];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_load_done <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_load_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                    end else if (unload_start) begin
                        r_state <= S_UNLOAD_RD;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (w_last) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_UNLOAD_RD: begin
                    r_out_data <= r_mem[r_cnt];
                    r_state    <= S_UNLOAD_HOLD;
                end
                S_UNLOAD_HOLD: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_UNLOAD_RD;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign statemt_q0  = r_q0;
    assign statemt_q1  = r_q1;
    assign out_data    = r_out_data;
    assign load_done   = r_load_done;
    assign busy        = ~w_idle;
    assign in_ready    = (r_state == S_LOAD);
    assign out_valid   = (r_state == S_UNLOAD_HOLD);
    // The final handshake itself is the done indication, so it follows out_ready directly.
    assign unload_done = (r_state == S_UNLOAD_HOLD) & out_ready & w_last;

endmodule
